// File: rtl/vu_meter_pkg.sv
// Shared types and helpers for the multi-channel VU meter.
// Optional peak-hold dot is enabled by defining VU_PEAK_HOLD_EN.
package vu_meter_pkg;

  typedef enum logic [1:0] {H_IDLE, H_HOLD, H_FALL} hold_state_t;

  // LED k threshold: 2^(w-2-step*(n-1-k)); exponents below zero clamp to 1.
  function automatic logic [63:0] vu_threshold(input int k, input int w, input int n, input int step);
    int e;
    e = w - 2 - step * (n - 1 - k);
    return (e < 0) ? 64'd1 : (64'd1 << e);
  endfunction

  // |x| for a sign-extended w-bit sample; the most-negative code saturates to 2^(w-1)-1.
  function automatic logic [63:0] vu_abs_sat(input logic signed [63:0] x, input int w);
    logic [63:0] a;
    logic [63:0] lim;
    lim = (64'd1 << (w - 1)) - 64'd1;
    a   = x[63] ? 64'(-x) : 64'(x);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/vu_meter_multi_channel.sv
// One meter channel: rectify, peak/decay, bar encode, sticky clip and (with
// VU_PEAK_HOLD_EN defined) the peak-hold dot FSM.
module vu_channel
  import vu_meter_pkg::*;
#(
  parameter int SAMPLE_W    = 32,
  parameter int NUM_LEDS    = 10,
  parameter int STEP        = 1,
  parameter int DECAY_SHIFT = 7,
  parameter int HOLD_TICKS  = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                audio_valid,
  input  logic                clip_clear,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [NUM_LEDS-1:0] led_bar,
  output logic [NUM_LEDS-1:0] hold_dot,
  output logic                clip
);

  localparam logic [SAMPLE_W-1:0] FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] abs_val;
  logic [SAMPLE_W-1:0] dec;
  logic [SAMPLE_W-1:0] peak_d, peak_q;
  logic [NUM_LEDS-1:0] led_bar_d, led_bar_q;
  logic                clip_d, clip_q;

  always_comb begin
    abs_val = SAMPLE_W'(vu_abs_sat(64'($signed(sample)), SAMPLE_W));
    dec     = peak_q >> DECAY_SHIFT;
    // Force a unit step once the shift underflows so the peak always lands on 0.
    if (dec == '0 && peak_q != '0) dec = SAMPLE_W'(1);
    peak_d = peak_q;
    if (audio_valid && abs_val > peak_q) peak_d = abs_val;
    else if (tick)                       peak_d = peak_q - dec;
    for (int k = 0; k < NUM_LEDS; k++)
      led_bar_d[k] = 64'(peak_q) >= vu_threshold(k, SAMPLE_W, NUM_LEDS, STEP);
    clip_d = clip_q;
    if (clip_clear)                         clip_d = 1'b0;
    if (audio_valid && abs_val >= FULL)     clip_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak_q    <= '0;
      led_bar_q <= '0;
      clip_q    <= 1'b0;
    end else begin
      peak_q    <= peak_d;
      led_bar_q <= led_bar_d;
      clip_q    <= clip_d;
    end
  end

  assign led_bar = led_bar_q;
  assign clip    = clip_q;

`ifdef VU_PEAK_HOLD_EN
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  hold_state_t         hold_state_d, hold_state_q;
  logic [LW-1:0]       level, hold_level_d, hold_level_q;
  logic [CW-1:0]       hold_cnt_d, hold_cnt_q;
  logic [NUM_LEDS-1:0] hold_dot_d, hold_dot_q;

  always_comb begin
    level = '0;
    for (int k = 0; k < NUM_LEDS; k++)
      if (led_bar_d[k]) level = level + LW'(1);
    hold_state_d = hold_state_q;
    hold_level_d = hold_level_q;
    hold_cnt_d   = hold_cnt_q;
    if (level > hold_level_q) begin
      hold_level_d = level;
      hold_cnt_d   = '0;
      hold_state_d = H_HOLD;
    end else begin
      case (hold_state_q)
        H_HOLD: if (tick) begin
          if (hold_cnt_q == CW'(HOLD_TICKS - 1)) hold_state_d = H_FALL;
          else                                   hold_cnt_d   = hold_cnt_q + CW'(1);
        end
        H_FALL: if (tick && hold_level_q != '0) begin
          hold_level_d = hold_level_q - LW'(1);
          if (hold_level_q == LW'(1)) hold_state_d = H_IDLE;
        end
        default: ;
      endcase
    end
    // Dot is decoded from the next level so it lines up with led_bar.
    for (int k = 0; k < NUM_LEDS; k++)
      hold_dot_d[k] = (hold_level_d == LW'(k + 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_state_q <= H_IDLE;
      hold_level_q <= '0;
      hold_cnt_q   <= '0;
      hold_dot_q   <= '0;
    end else begin
      hold_state_q <= hold_state_d;
      hold_level_q <= hold_level_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_dot_q   <= hold_dot_d;
    end
  end

  assign hold_dot = hold_dot_q;
`else
  assign hold_dot = '0;
`endif

endmodule

// File: rtl/vu_meter_multi.sv
// N-channel VU meter top: shared decay tick counter plus per-channel meters.
// Peak-hold dots are built only when VU_PEAK_HOLD_EN is defined.
module vu_meter_multi
  import vu_meter_pkg::*;
#(
  parameter int SAMPLE_W     = 32,
  parameter int NUM_CH       = 2,
  parameter int NUM_LEDS     = 10,
  parameter int STEP         = 1,
  parameter int DECAY_PERIOD = 50000,
  parameter int DECAY_SHIFT  = 7,
  parameter int HOLD_TICKS   = 500
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH*SAMPLE_W-1:0]   audio_in,
  input  logic                         audio_valid,
  input  logic                         clip_clear,
  output logic [NUM_CH*NUM_LEDS-1:0]   led_bar,
  output logic [NUM_CH*NUM_LEDS-1:0]   hold_dot,
  output logic [NUM_CH-1:0]            clip
);

  localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  logic [TW-1:0] tick_cnt_d, tick_cnt_q;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(DECAY_PERIOD - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vu_channel #(
      .SAMPLE_W   (SAMPLE_W),
      .NUM_LEDS   (NUM_LEDS),
      .STEP       (STEP),
      .DECAY_SHIFT(DECAY_SHIFT),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .audio_valid(audio_valid),
      .clip_clear (clip_clear),
      .sample     (audio_in[c*SAMPLE_W +: SAMPLE_W]),
      .led_bar    (led_bar[c*NUM_LEDS +: NUM_LEDS]),
      .hold_dot   (hold_dot[c*NUM_LEDS +: NUM_LEDS]),
      .clip       (clip[c])
    );
  end

endmodule

// File: tb/tb_vu_meter_multi.sv
// Directed bench for vu_meter_multi: a stereo meter with fast decay and a
// mono meter with halving decay for the peak-hold dot sequence.
module tb_vu_meter_multi;

`ifdef VU_PEAK_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] audio_in = '0;
  logic        audio_valid = 1'b0;
  logic        clip_clear = 1'b0;
  logic [19:0] led_bar, hold_dot;
  logic [1:0]  clip;

  logic [31:0] h_audio = '0;
  logic        h_valid = 1'b0;
  logic [9:0]  h_bar, h_dot;
  logic        h_clip;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  vu_meter_multi #(
    .SAMPLE_W(32), .NUM_CH(2), .NUM_LEDS(10), .STEP(1),
    .DECAY_PERIOD(4), .DECAY_SHIFT(7), .HOLD_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .audio_in(audio_in), .audio_valid(audio_valid),
    .clip_clear(clip_clear), .led_bar(led_bar), .hold_dot(hold_dot), .clip(clip)
  );

  vu_meter_multi #(
    .SAMPLE_W(32), .NUM_CH(1), .NUM_LEDS(10), .STEP(1),
    .DECAY_PERIOD(4), .DECAY_SHIFT(1), .HOLD_TICKS(3)
  ) dut_h (
    .clock(clock), .reset(reset), .audio_in(h_audio), .audio_valid(h_valid),
    .clip_clear(clip_clear), .led_bar(h_bar), .hold_dot(h_dot), .clip(h_clip)
  );

  always #5 clock = ~clock;

  // Mirrors the decay counter phase: after each edge, counter == cyc % 4.
  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic align(input int m);
    step(1);
    for (int i = 0; i < 4 && (cyc % 4) != m; i++) step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev, cur;
    int bad;
    logic [9:0] exp_dot [0:8];
    exp_dot = '{10'h010, 10'h010, 10'h010, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001, 10'h000};

    // Reset state
    step(2);
    chk("rst_bar", led_bar, 20'h0);
    chk("rst_dot", hold_dot, 20'h0);
    chk("rst_clip", clip, 2'b00);
    reset = 1'b0;

    // Decay from 0x100: 0xFE, 0xFD, ... monotone down to exactly 0
    align(0);
    audio_in = {32'h0, 32'h0000_0100}; audio_valid = 1'b1;
    step(1); audio_valid = 1'b0;
    chk("dec_load", dut.g_ch[0].u_ch.peak_q, 32'h100);
    step(3);
    chk("dec_tick1", dut.g_ch[0].u_ch.peak_q, 32'hFE);
    step(4);
    chk("dec_tick2", dut.g_ch[0].u_ch.peak_q, 32'hFD);
    prev = 32'hFD; bad = 0;
    for (int i = 0; i < 260; i++) begin
      step(4);
      cur = dut.g_ch[0].u_ch.peak_q;
      if (cur > prev) bad++;
      prev = cur;
    end
    chk("dec_mono", bad, 0);
    chk("dec_zero", dut.g_ch[0].u_ch.peak_q, 32'h0);

    // Full bar on ch0, latency N+2
    align(0);
    audio_in = {32'h0, 32'h4000_0000}; audio_valid = 1'b1;
    step(1); audio_valid = 1'b0;
    chk("bar_n1", led_bar, 20'h0);
    step(1);
    chk("bar_n2", led_bar, 20'h003FF);
    chk("dot_full", hold_dot, HOLD_EN ? 20'h00200 : 20'h0);
    chk("clip_none", clip, 2'b00);

    // Sample above peak coincident with a tick: no decay applied
    align(2);
    audio_in = {32'h0000_1000, 32'h0}; audio_valid = 1'b1;
    step(1);
    audio_in = {32'h0000_2000, 32'h0};
    step(1); audio_valid = 1'b0;
    chk("upd_vs_tick", dut.g_ch[1].u_ch.peak_q, 32'h2000);

    // Saturating rectify and sticky clip
    audio_in = {32'h8000_0000, 32'h0}; audio_valid = 1'b1;
    step(1); audio_valid = 1'b0;
    chk("clip_set", clip, 2'b10);
    chk("abs_sat", dut.g_ch[1].u_ch.peak_q, 32'h7FFF_FFFF);
    step(1);
    chk("bar_ch1", led_bar[19:10], 10'h3FF);
    step(5);
    chk("clip_hold", clip, 2'b10);
    clip_clear = 1'b1;
    step(1); clip_clear = 1'b0;
    chk("clip_clr", clip, 2'b00);
    audio_in = {32'h0, 32'h7FFF_FFFE}; audio_valid = 1'b1;
    step(1);
    chk("clip_below", clip, 2'b00);
    audio_in = {32'h0, 32'h7FFF_FFFF};
    step(1); audio_valid = 1'b0;
    chk("clip_max", clip, 2'b01);
    audio_in = {32'h8000_0000, 32'h0}; audio_valid = 1'b1; clip_clear = 1'b1;
    step(1); audio_valid = 1'b0; clip_clear = 1'b0;
    chk("clip_set_wins", clip, 2'b10);

    // Asynchronous reset mid-decay, then normal operation
    step(3);
    reset = 1'b1;
    #2;
    chk("arst_bar", led_bar, 20'h0);
    chk("arst_dot", hold_dot, 20'h0);
    chk("arst_clip", clip, 2'b00);
    chk("arst_peak", dut.g_ch[1].u_ch.peak_q, 32'h0);
    step(1);
    reset = 1'b0;
    audio_in = {32'hFFC0_0000, 32'h0040_0000}; audio_valid = 1'b1;
    step(1); audio_valid = 1'b0;
    chk("post_rst_n1", led_bar, 20'h0);
    step(1);
    chk("post_rst_bar", led_bar, 20'h00C03);
    chk("post_rst_clip", clip, 2'b00);

    // Peak-hold dot: dwell 3 ticks at LED 4, then step down to empty
    align(0);
    h_audio = 32'h0200_0000; h_valid = 1'b1;
    step(1); h_valid = 1'b0;
    step(1);
    chk("h_bar", h_bar, 10'h01F);
    chk("h_dot0", h_dot, HOLD_EN ? exp_dot[0] : 10'h0);
    for (int m = 1; m < 9; m++) begin
      step(4);
      if (m == 1) chk("h_bar_dec", h_bar, 10'h00F);
      chk($sformatf("h_dot%0d", m), h_dot, HOLD_EN ? exp_dot[m] : 10'h0);
    end
    chk("h_clip", h_clip, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
